// File: rtl/score_counter_if.sv
// Button inputs and BCD score outputs of the score keeper, bundled for the
// driver side (master) and the score_counter itself (slave).
interface score_counter_if;
  logic       btn_p1_i;
  logic       btn_p2_i;
  logic       btn_undo_i;
  logic [3:0] p1_tens_o;
  logic [3:0] p1_ones_o;
  logic [3:0] p2_tens_o;
  logic [3:0] p2_ones_o;
  logic       score_evt_o;

  modport master (
    output btn_p1_i, btn_p2_i, btn_undo_i,
    input  p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, score_evt_o
  );

  modport slave (
    input  btn_p1_i, btn_p2_i, btn_undo_i,
    output p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, score_evt_o
  );
endinterface

// File: rtl/score_counter.sv
// Two-player BCD score keeper: synchronised, debounced buttons, multi-level
// undo from a scorer-history ring, and clear-all on a long undo hold.
module score_counter #(
  parameter int DEBOUNCE_MS = 20,
  parameter int CLEAR_MS    = 2000,
  parameter int HIST_DEPTH  = 8
) (
  input  logic           clk_1khz,
  input  logic           rst_i,
  score_counter_if.slave bus
);
  localparam int DBW = $clog2(DEBOUNCE_MS + 1);
  localparam int HTW = $clog2(CLEAR_MS + 1);
  localparam int PW  = $clog2(HIST_DEPTH);
  localparam int CW  = $clog2(HIST_DEPTH + 1);

  logic [2:0] raw;
  logic [2:0] db;
  logic [2:0] press;

  // Bit order throughout: 0 = P1, 1 = P2, 2 = undo.
  assign raw = {bus.btn_undo_i, bus.btn_p2_i, bus.btn_p1_i};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic           s1_q;
      logic           s2_q;
      logic           db_q;
      logic           press_q;
      logic [DBW-1:0] cnt_q;

      always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          db_q    <= 1'b0;
          press_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          s1_q    <= raw[gi];
          s2_q    <= s1_q;
          press_q <= 1'b0;
          if (s2_q == db_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DBW'(DEBOUNCE_MS - 1)) begin
            db_q    <= s2_q;
            cnt_q   <= '0;
            press_q <= s2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign db[gi]    = db_q;
      assign press[gi] = press_q;
    end
  endgenerate

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [7:0]     p1_q, p1_d;
  logic [7:0]     p2_q, p2_d;
  logic           evt_q, evt_d;
  logic           hist_q [HIST_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  hcount_q, hcount_d;
  logic           hold_q, hold_d;
  logic [HTW-1:0] hold_cnt_q, hold_cnt_d;
  logic           push_en;
  logic           push_id;
  logic [PW-1:0]  top_ptr;
  logic           top_id;
  logic           clear_fire;

  assign top_ptr    = wr_ptr_q - 1'b1;
  assign top_id     = hist_q[top_ptr];
  assign clear_fire = hold_q && db[2] && (hold_cnt_q == HTW'(CLEAR_MS - 1));

  always_comb begin
    p1_d       = p1_q;
    p2_d       = p2_q;
    evt_d      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    hcount_d   = hcount_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    push_en    = 1'b0;
    push_id    = press[1];

    // Hold timer: armed by an undo press, fires once, dropped on release.
    if (clear_fire) begin
      hold_d     = 1'b0;
      hold_cnt_d = '0;
    end else if (press[2]) begin
      hold_d     = 1'b1;
      hold_cnt_d = '0;
    end else if (hold_q) begin
      if (!db[2]) hold_d = 1'b0;
      else        hold_cnt_d = hold_cnt_q + 1'b1;
    end

    if (clear_fire) begin
      p1_d     = 8'h00;
      p2_d     = 8'h00;
      hcount_d = '0;
      evt_d    = 1'b1;
    end else if (press[2]) begin
      if (hcount_q != '0) begin
        wr_ptr_d = top_ptr;
        hcount_d = hcount_q - 1'b1;
        if (!top_id && p1_q != 8'h00) begin
          p1_d  = bcd_dec(p1_q);
          evt_d = 1'b1;
        end else if (top_id && p2_q != 8'h00) begin
          p2_d  = bcd_dec(p2_q);
          evt_d = 1'b1;
        end
      end
    end else if (press[0] ^ press[1]) begin
      if (press[0] && p1_q != 8'h99) begin
        p1_d    = bcd_inc(p1_q);
        push_en = 1'b1;
      end else if (press[1] && p2_q != 8'h99) begin
        p2_d    = bcd_inc(p2_q);
        push_en = 1'b1;
      end
      if (push_en) begin
        evt_d    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (hcount_q != CW'(HIST_DEPTH)) hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      p1_q       <= 8'h00;
      p2_q       <= 8'h00;
      evt_q      <= 1'b0;
      wr_ptr_q   <= '0;
      hcount_q   <= '0;
      hold_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      evt_q      <= evt_d;
      wr_ptr_q   <= wr_ptr_d;
      hcount_q   <= hcount_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      if (push_en) hist_q[wr_ptr_q] <= push_id;
    end
  end

  assign bus.p1_tens_o   = p1_q[7:4];
  assign bus.p1_ones_o   = p1_q[3:0];
  assign bus.p2_tens_o   = p2_q[7:4];
  assign bus.p2_ones_o   = p2_q[3:0];
  assign bus.score_evt_o = evt_q;
endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: cycle-by-cycle reference model on every tick, a
// table of press sequences with expected scores, and directed corner cases.
module tb_score_counter;
  localparam int N = 20;
  localparam int C = 2000;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_counter_if bus ();

  score_counter #(.DEBOUNCE_MS(N), .CLEAR_MS(C), .HIST_DEPTH(D)) dut (
    .clk_1khz (clk),
    .rst_i    (rst),
    .bus      (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int evt_cnt = 0;
  int last_evt_cyc = 0;
  int first_evt_cyc = -1;

  // Reference model: integer scores, a queue of scorer IDs, and per button
  // the last N synchronised samples; a level flips once all N disagree with it.
  int           m_p1, m_p2, m_age;
  int           m_hist[$];
  logic [2:0]   m_s1, m_s2, m_lvl, m_press;
  logic [N-1:0] m_win [3];
  logic         m_evt, m_hold;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  function automatic int p1_dut();
    return int'(bus.p1_tens_o) * 10 + int'(bus.p1_ones_o);
  endfunction

  function automatic int p2_dut();
    return int'(bus.p2_tens_o) * 10 + int'(bus.p2_ones_o);
  endfunction

  task automatic model_step();
    logic [2:0] raw;
    logic       clr;
    raw = {bus.btn_undo_i, bus.btn_p2_i, bus.btn_p1_i};
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_hist.delete();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
      for (int b = 0; b < 3; b++) m_win[b] = '0;
      m_evt = 1'b0; m_hold = 1'b0; m_age = 0;
      return;
    end
    m_evt = 1'b0;
    clr = m_hold && m_lvl[2] && (m_age + 1 == C);
    if (m_hold) begin
      if (!m_lvl[2]) m_hold = 1'b0;
      else begin
        m_age++;
        if (m_age == C) m_hold = 1'b0;
      end
    end
    if (m_press[2]) begin
      m_hold = 1'b1;
      m_age  = 0;
    end
    if (clr) begin
      m_p1 = 0; m_p2 = 0; m_hist.delete(); m_evt = 1'b1;
    end else if (m_press[2]) begin
      if (m_hist.size() > 0) begin
        int id;
        id = m_hist.pop_back();
        if (id == 0 && m_p1 > 0) begin m_p1--; m_evt = 1'b1; end
        if (id == 1 && m_p2 > 0) begin m_p2--; m_evt = 1'b1; end
      end
    end else if (m_press[0] != m_press[1]) begin
      if (m_press[0] && m_p1 < 99) begin
        m_p1++; m_hist.push_back(0); m_evt = 1'b1;
      end else if (m_press[1] && m_p2 < 99) begin
        m_p2++; m_hist.push_back(1); m_evt = 1'b1;
      end
      if (m_hist.size() > D) void'(m_hist.pop_front());
    end
    for (int b = 0; b < 3; b++) begin
      m_win[b]   = {m_win[b][N-2:0], m_s2[b]};
      m_press[b] = 1'b0;
      if (m_win[b] == (m_lvl[b] ? {N{1'b0}} : {N{1'b1}})) begin
        m_press[b] = !m_lvl[b];
        m_lvl[b]   = !m_lvl[b];
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("model_p1", p1_dut(), m_p1);
    check("model_p2", p2_dut(), m_p2);
    check("model_evt", int'(bus.score_evt_o), int'(m_evt));
    if (bus.score_evt_o) begin
      evt_cnt++;
      last_evt_cyc = cyc;
      if (first_evt_cyc < 0) first_evt_cyc = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input logic [2:0] m);
    bus.btn_p1_i   = m[0];
    bus.btn_p2_i   = m[1];
    bus.btn_undo_i = m[2];
  endtask

  task automatic press(input logic [2:0] m, input int hi, input int lo);
    set_btn(m);
    ticks(hi);
    set_btn(3'b000);
    ticks(lo);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_btn(3'b000);
    ticks(3);
    rst = 1'b0;
    ticks(2);
  endtask

  typedef struct {
    logic [2:0] btn;
    int         exp_p1;
    int         exp_p2;
    int         exp_evts;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int rise;
    int e0;
    vecs[0]  = '{3'b001, 1, 0, 1};
    vecs[1]  = '{3'b010, 1, 1, 1};
    vecs[2]  = '{3'b010, 1, 2, 1};
    vecs[3]  = '{3'b011, 1, 2, 0};
    vecs[4]  = '{3'b001, 2, 2, 1};
    vecs[5]  = '{3'b100, 1, 2, 1};
    vecs[6]  = '{3'b101, 1, 1, 1};
    vecs[7]  = '{3'b100, 1, 0, 1};
    vecs[8]  = '{3'b100, 0, 0, 1};
    vecs[9]  = '{3'b100, 0, 0, 0};
    vecs[10] = '{3'b010, 0, 1, 1};

    set_btn(3'b000);
    do_reset();
    check("reset_p1", p1_dut(), 0);
    check("reset_p2", p2_dut(), 0);
    check("reset_evt", int'(bus.score_evt_o), 0);

    // Table-driven press sequences.
    for (int i = 0; i < 11; i++) begin
      e0 = evt_cnt;
      press(vecs[i].btn, 50, 50);
      check($sformatf("vec%0d_p1", i), p1_dut(), vecs[i].exp_p1);
      check($sformatf("vec%0d_p2", i), p2_dut(), vecs[i].exp_p2);
      check($sformatf("vec%0d_evts", i), evt_cnt - e0, vecs[i].exp_evts);
    end

    // Ten clean P1 presses with latency measured from the raw rise.
    do_reset();
    e0 = evt_cnt;
    for (int i = 0; i < 10; i++) begin
      rise = cyc;
      press(3'b001, 50, 50);
      check("t1_latency", last_evt_cyc - (rise + 1), N + 2);
    end
    check("t1_p1", p1_dut(), 10);
    check("t1_p2", p2_dut(), 0);
    check("t1_evts", evt_cnt - e0, 10);

    // Short pulse, bounce train, settle: one P2 point; 19-cycle glitch ignored.
    e0 = evt_cnt;
    press(3'b010, 15, 30);
    for (int i = 0; i < 20; i++) begin
      set_btn((i % 2 == 0) ? 3'b010 : 3'b000);
      ticks(5);
    end
    press(3'b010, 60, 60);
    check("t2_p2", p2_dut(), 1);
    check("t2_evts", evt_cnt - e0, 1);
    e0 = evt_cnt;
    press(3'b010, 19, 60);
    check("t2_glitch_p2", p2_dut(), 1);
    check("t2_glitch_evts", evt_cnt - e0, 0);

    // Saturation at 99 followed by two undos.
    do_reset();
    for (int i = 0; i < 99; i++) press(3'b001, 25, 25);
    check("t3_p1_99", p1_dut(), 99);
    e0 = evt_cnt;
    press(3'b001, 25, 25);
    check("t3_sat_p1", p1_dut(), 99);
    check("t3_sat_evts", evt_cnt - e0, 0);
    press(3'b100, 25, 25);
    check("t3_undo1", p1_dut(), 98);
    press(3'b100, 25, 25);
    check("t3_undo2", p1_dut(), 97);

    // History depth: only the newest D points can be undone.
    do_reset();
    for (int i = 0; i < 10; i++) press(3'b001, 30, 30);
    e0 = evt_cnt;
    for (int i = 0; i < 8; i++) press(3'b100, 30, 30);
    check("t5_p1_after8", p1_dut(), 2);
    press(3'b100, 30, 30);
    press(3'b100, 30, 30);
    check("t5_p1_after10", p1_dut(), 2);
    check("t5_evts", evt_cnt - e0, 8);

    // Long undo hold: undo at press, one clear CLEAR_MS cycles later.
    do_reset();
    for (int i = 0; i < 5; i++) press(3'b001, 30, 30);
    for (int i = 0; i < 3; i++) press(3'b010, 30, 30);
    e0 = evt_cnt;
    first_evt_cyc = -1;
    set_btn(3'b100);
    ticks(100);
    check("t6_undo_p1", p1_dut(), 5);
    check("t6_undo_p2", p2_dut(), 2);
    ticks(2000);
    set_btn(3'b000);
    ticks(60);
    check("t6_clear_p1", p1_dut(), 0);
    check("t6_clear_p2", p2_dut(), 0);
    check("t6_evts", evt_cnt - e0, 2);
    check("t6_clear_delay", last_evt_cyc - first_evt_cyc, C);

    // Reset during a hold: no clear pulse afterwards.
    for (int i = 0; i < 2; i++) press(3'b001, 30, 30);
    set_btn(3'b100);
    ticks(1000);
    e0 = evt_cnt;
    rst = 1'b1;
    set_btn(3'b000);
    ticks(3);
    rst = 1'b0;
    ticks(2100);
    check("t6r_evts", evt_cnt - e0, 0);
    check("t6r_p1", p1_dut(), 0);
    check("t6r_p2", p2_dut(), 0);

    // Random presses, glitches and bounces against the model.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [2:0] m;
      int hi;
      m  = 3'($urandom_range(1, 7));
      hi = $urandom_range(5, 60);
      if (m[2] && $urandom_range(0, 9) == 0) hi = 2100;
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 30; j++) begin
          set_btn(3'($urandom_range(0, 7)));
          tick();
        end
      end
      press(m, hi, $urandom_range(5, 60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
